// File: rtl/prbs16_checker_if.sv
// prbs16_checker_if
//   Serial receive bundle feeding the PRBS16 checker.
//   Signals:
//     rx_bit   - received serial data bit
//     rx_valid - rx_bit is meaningful on this cycle
//   Modports:
//     master - drives the stream (data source / testbench)
//     slave  - consumes the stream (prbs16_checker)
interface prbs16_checker_if;
  logic rx_bit;
  logic rx_valid;

  modport master (output rx_bit, output rx_valid);
  modport slave  (input  rx_bit, input  rx_valid);
endinterface

// File: rtl/prbs16_checker.sv
// prbs16_checker
//   Self-synchronising checker for a 16-bit Fibonacci PRBS
//   (b(m) = b(m-16) ^ b(m-14) ^ b(m-13) ^ b(m-11)). It fills a 16-bit
//   history, verifies LOCK_MATCHES consecutive correct predictions before
//   declaring lock, counts mispredictions while locked, and drops back to
//   verification after LOSS_ERRORS consecutive misses.
//   Ports:
//     CLOCK_50  in   sole clock, rising edge
//     KEY[0]    in   synchronous active-low reset
//     KEY[1]    in   synchronous active-low error-counter clear
//     rx        in   serial stream (rx_bit, rx_valid), slave modport
//     state     out  2-bit FSM state: FILL=0, VERIFY=1, LOCKED=2
//     locked    out  high exactly while state is LOCKED
//     err_count out  saturating count of mispredicted bits while LOCKED
//     HEX3..0   out  err_count nibbles [15:12]..[3:0], active-low 7-seg
module prbs16_checker #(
  parameter int unsigned LOCK_MATCHES = 32,
  parameter int unsigned LOSS_ERRORS  = 4
) (
  input  logic                   CLOCK_50,
  input  logic [1:0]             KEY,
  prbs16_checker_if.slave        rx,
  output logic [1:0]             state,
  output logic                   locked,
  output logic [15:0]            err_count,
  output logic [6:0]             HEX3,
  output logic [6:0]             HEX2,
  output logic [6:0]             HEX1,
  output logic [6:0]             HEX0
);

  localparam int unsigned MATCH_W = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned MISS_W  = $clog2(LOSS_ERRORS + 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Active-low seven-segment pattern (gfedcba) for one hex digit.
  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      4'hF:    hex_seg = 7'b0001110;
      default: hex_seg = 7'b1111111;
    endcase
  endfunction

  // h_r[k] holds the bit received k+1 valid samples ago.
  logic [15:0]        h_r;
  logic [3:0]         fill_r;
  logic [MATCH_W-1:0] match_r;
  logic [MISS_W-1:0]  miss_r;
  state_t             state_r;
  logic               locked_r;
  logic [15:0]        err_r;
  logic [6:0]         hex3_r, hex2_r, hex1_r, hex0_r;

  logic [15:0]        h_s;
  logic [3:0]         fill_s;
  logic [MATCH_W-1:0] match_s;
  logic [MISS_W-1:0]  miss_s;
  state_t             state_s;
  logic               err_inc_s;
  logic [15:0]        err_s;
  logic               predict_s;
  logic               bit_ok_s;

  // Prediction from the pre-shift history; an all-zero history followed by
  // a zero is rejected so a dead (stuck-low) line can never lock.
  always_comb begin
    predict_s = h_r[15] ^ h_r[13] ^ h_r[12] ^ h_r[10];
    bit_ok_s  = (rx.rx_bit == predict_s) && !((h_r == 16'h0000) && !rx.rx_bit);
  end

  // Next-state logic: history shift plus FILL/VERIFY/LOCKED sequencing.
  always_comb begin
    state_s   = state_r;
    fill_s    = fill_r;
    match_s   = match_r;
    miss_s    = miss_r;
    h_s       = h_r;
    err_inc_s = 1'b0;
    if (rx.rx_valid) begin
      // The received bit is always shifted in, so the checker re-seeds
      // itself from the line rather than free-running.
      h_s = {h_r[14:0], rx.rx_bit};
      case (state_r)
        ST_FILL: begin
          if (fill_r == 4'd15) begin
            state_s = ST_VERIFY;
            fill_s  = 4'd0;
            match_s = '0;
          end else begin
            fill_s = fill_r + 4'd1;
          end
        end
        ST_VERIFY: begin
          if (bit_ok_s) begin
            if (match_r == MATCH_W'(LOCK_MATCHES - 1)) begin
              state_s = ST_LOCKED;
              match_s = '0;
              miss_s  = '0;
            end else begin
              match_s = match_r + MATCH_W'(1);
            end
          end else begin
            match_s = '0;
          end
        end
        ST_LOCKED: begin
          if (bit_ok_s) begin
            miss_s = '0;
          end else begin
            err_inc_s = 1'b1;
            if (miss_r == MISS_W'(LOSS_ERRORS - 1)) begin
              state_s = ST_VERIFY;
              match_s = '0;
              miss_s  = '0;
            end else begin
              miss_s = miss_r + MISS_W'(1);
            end
          end
        end
        default: begin
          state_s = ST_FILL;
          fill_s  = 4'd0;
          match_s = '0;
          miss_s  = '0;
        end
      endcase
    end else begin
      h_s = h_r;
    end
  end

  // Error counter: clear wins over increment; increments saturate.
  always_comb begin
    if (!KEY[1]) begin
      err_s = 16'h0000;
    end else if (err_inc_s && (err_r != 16'hFFFF)) begin
      err_s = err_r + 16'd1;
    end else begin
      err_s = err_r;
    end
  end

  // State and output registers; HEX is decoded from the next count so the
  // displays stay aligned with err_count.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      h_r      <= 16'h0000;
      fill_r   <= 4'd0;
      match_r  <= '0;
      miss_r   <= '0;
      state_r  <= ST_FILL;
      locked_r <= 1'b0;
      err_r    <= 16'h0000;
      hex3_r   <= 7'b1000000;
      hex2_r   <= 7'b1000000;
      hex1_r   <= 7'b1000000;
      hex0_r   <= 7'b1000000;
    end else begin
      h_r      <= h_s;
      fill_r   <= fill_s;
      match_r  <= match_s;
      miss_r   <= miss_s;
      state_r  <= state_s;
      locked_r <= (state_s == ST_LOCKED);
      err_r    <= err_s;
      hex3_r   <= hex_seg(err_s[15:12]);
      hex2_r   <= hex_seg(err_s[11:8]);
      hex1_r   <= hex_seg(err_s[7:4]);
      hex0_r   <= hex_seg(err_s[3:0]);
    end
  end

  assign state     = state_r;
  assign locked    = locked_r;
  assign err_count = err_r;
  assign HEX3      = hex3_r;
  assign HEX2      = hex2_r;
  assign HEX1      = hex1_r;
  assign HEX0      = hex0_r;

endmodule

// File: doc/prbs16_checker.md
PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 Parameter LOCK_MATCHES, default 32: consecutive correct predictions needed to declare lock.
REQ-002 Parameter LOSS_ERRORS, default 4: consecutive mispredictions in LOCKED that drop lock.
REQ-003 CLOCK_50  in  1  sole clock; all state updates on its rising edge.
REQ-004 KEY  in  2  KEY[0] = reset, synchronous, active-low; KEY[1] = error-counter clear, synchronous, active-low.
REQ-005 rx_bit  in  1  received serial data bit.
REQ-006 rx_valid  in  1  rx_bit is sampled only on cycles where rx_valid=1.
REQ-007 state  out  2  FSM state: FILL=0, VERIFY=1, LOCKED=2; value 3 unused.
REQ-008 locked  out  1  1 exactly when state=LOCKED.
REQ-009 err_count  out  16  count of mispredicted bits while LOCKED.
REQ-010 HEX3, HEX2, HEX1, HEX0  out  7 each  err_count[15:12], [11:8], [7:4], [3:0] as hex digits, active-low segments; 0=1000000, 1=1111001, …, F=0001110.

Function
REQ-011 16-bit history H[0:15]; on each valid bit, H shifts to H <= {rx_bit, H[0:14]}, so H[k] holds the bit received k+1 valid samples earlier.
REQ-012 Predicted bit = H[15]^H[13]^H[12]^H[10], computed from H before the shift; this matches the 16-bit Fibonacci LFSR recurrence b(m)=b(m-16)^b(m-14)^b(m-13)^b(m-11).
REQ-013 Match = (rx_bit == predicted) AND NOT (H==0 AND rx_bit==0); an all-zero history followed by a 0 counts as a mismatch (stuck-at-zero guard).
REQ-014 H shifts in the received bit, never the predicted bit, in every state (self-synchronising).
REQ-015 Cycles with rx_valid=0 change no state, counter, or output.
REQ-016 FILL: a fill counter counts valid bits; on the 16th valid bit, go to VERIFY with match counter = 0; no comparisons in FILL.
REQ-017 VERIFY: match → match counter +1; when it reaches LOCK_MATCHES, go to LOCKED and clear the miss counter; mismatch → match counter = 0, stay in VERIFY.
REQ-018 LOCKED: match → miss counter = 0; mismatch → err_count +1 and miss counter +1; when the miss counter reaches LOSS_ERRORS, go to VERIFY with match counter = 0.
REQ-019 err_count increments only in LOCKED, saturates at 16'hFFFF, and never wraps.
REQ-020 KEY[1]=0 sets err_count to 0 on that edge; clear beats a simultaneous increment; FSM unaffected.
REQ-021 All outputs are registered or decoded from registers; state, locked, and err_count reflect a valid bit on the edge that samples it (visible the following cycle).
REQ-022 Lock latency from reset with a clean stream: locked=1 after exactly 16+LOCK_MATCHES valid bits.

Reset
REQ-023 KEY[0]=0 at a rising edge: H=0, fill, match and miss counters=0, state=FILL, locked=0, err_count=0; overrides KEY[1] and rx_valid.
REQ-024 Reset mid-operation (any state) behaves identically; after reset the outputs read state=0, locked=0, and HEX3..HEX0=1000000.
REQ-025 There is no asynchronous reset path; KEY[0] has no effect between clock edges.

Verification
REQ-026 Clean lock: reset, then feed 48 valid bits of the LFSR sequence from seed Q[0:15]=1000_0000_0000_0000 (bit shifted in each step) → locked rises after the 48th bit, err_count=0, state=2.
REQ-027 Single error: after lock, invert one bit → err_count=1, HEX0=1111001, locked stays 1; the next 16 clean bits yield further mispredictions only while the bad bit is inside the taps, and locked stays 1 if consecutive misses are fewer than 4.
REQ-028 Loss of lock: after lock, feed 4 consecutive inverted bits that all mispredict → err_count=4, state=1 on the 4th; resume the clean stream → locked=1 again within 16+32 valid bits.
REQ-029 Stuck-at-zero: reset, rx_valid=1, rx_bit=0 for 500 cycles → state never reaches 2, err_count=0.
REQ-030 Gaps and controls: clean stream with rx_valid toggled 1-0-1 randomly → same lock bit index as REQ-026. KEY[1]=0 on the same edge as a mispredicted bit → err_count=0. KEY[0]=0 while locked → next cycle state=0, locked=0, err_count=0.
